// File: rtl/sqrt_iter.sv
// rtl/sqrt_iter.sv - iterative restoring integer square root with start/busy/done handshake
module sqrt_iter #(
  parameter int WIDTH  = 16,
  parameter int UNROLL = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     radicand,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH/2-1:0]   root,
  output logic [WIDTH/2:0]     remainder
);

  localparam int HW = WIDTH / 2;
  localparam int RW = HW + 2;
  localparam int C  = WIDTH / (2 * UNROLL);
  localparam int CW = (C > 1) ? $clog2(C) : 1;

  if ((WIDTH % 2) != 0 || WIDTH < 4 || (HW % UNROLL) != 0) begin : g_param_check
    $error("sqrt_iter: WIDTH must be even and >= 4, and UNROLL must divide WIDTH/2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_n;
  logic              load;
  logic [WIDTH-1:0]  a, a_n;
  logic [HW-1:0]     q, q_n;
  logic [RW-1:0]     r, r_n, r_sh, trial;
  logic [CW-1:0]     cnt;

  // UNROLL restoring steps chained combinationally; the last one feeds the registers
  always_comb begin
    q_n   = q;
    r_n   = r;
    a_n   = a;
    r_sh  = '0;
    trial = '0;
    for (int i = 0; i < UNROLL; i++) begin
      r_sh  = {r_n[RW-3:0], a_n[WIDTH-1 -: 2]};
      a_n   = a_n << 2;
      trial = {q_n, 2'b01};
      if (r_sh >= trial) begin
        r_n = r_sh - trial;
        q_n = {q_n[HW-2:0], 1'b1};
      end else begin
        r_n = r_sh;
        q_n = {q_n[HW-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (cnt == '0) state_n = DONE;
      end
      DONE: begin
        load    = start;
        state_n = start ? RUN : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      q         <= '0;
      r         <= '0;
      cnt       <= '0;
      root      <= '0;
      remainder <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        a   <= radicand;
        q   <= '0;
        r   <= '0;
        cnt <= CW'(C - 1);
      end else if (state == RUN) begin
        a <= a_n;
        q <= q_n;
        r <= r_n;
        if (cnt == '0) begin
          root      <= q_n;
          remainder <= r_n[HW:0];
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_sqrt_iter.sv
// tb/tb_sqrt_iter.sv - directed and invariant checks for sqrt_iter at three parameter sets
module tb_sqrt_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [15:0] rad_a = '0, rad_b = '0;
  logic [31:0] rad_c = '0;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [7:0]  root_a, root_b;
  logic [15:0] root_c;
  logic [8:0]  rem_a, rem_b;
  logic [16:0] rem_c;

  sqrt_iter #(.WIDTH(16), .UNROLL(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .radicand(rad_a),
    .busy(busy_a), .done(done_a), .root(root_a), .remainder(rem_a));
  sqrt_iter #(.WIDTH(16), .UNROLL(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .radicand(rad_b),
    .busy(busy_b), .done(done_b), .root(root_b), .remainder(rem_b));
  sqrt_iter #(.WIDTH(32), .UNROLL(2)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .radicand(rad_c),
    .busy(busy_c), .done(done_c), .root(root_c), .remainder(rem_c));

  int          sel = 0;
  logic        cur_busy, cur_done;
  logic [31:0] cur_root, cur_rem;

  always_comb begin
    cur_busy = busy_a; cur_done = done_a;
    cur_root = 32'(root_a); cur_rem = 32'(rem_a);
    case (sel)
      1: begin cur_busy = busy_b; cur_done = done_b; cur_root = 32'(root_b); cur_rem = 32'(rem_b); end
      2: begin cur_busy = busy_c; cur_done = done_c; cur_root = 32'(root_c); cur_rem = 32'(rem_c); end
      default: ;
    endcase
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int s, input logic st, input logic [31:0] v);
    case (s)
      0: begin start_a = st; rad_a = v[15:0]; end
      1: begin start_b = st; rad_b = v[15:0]; end
      default: begin start_c = st; rad_c = v; end
    endcase
  endtask

  logic [31:0] got_root, got_rem;
  int          got_lat, got_busy;

  // Start one operation, wait for done (bounded), and capture result, latency and busy cycles
  task automatic run_op(input int s, input logic [31:0] v);
    sel = s;
    @(negedge clk);
    drive(s, 1'b1, v);
    @(posedge clk);
    #1 drive(s, 1'b0, v);
    got_lat = -1; got_busy = 0; got_root = '0; got_rem = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (cur_done) begin
        got_lat = n; got_root = cur_root; got_rem = cur_rem;
        check("busy_done_exclusive", 64'(cur_busy), 64'd0);
        break;
      end
      if (cur_busy) got_busy++;
    end
  endtask

  task automatic expect_op(input int s, input logic [31:0] v, input logic [31:0] er,
                           input logic [31:0] erem, input int lat);
    run_op(s, v);
    check($sformatf("latency_%0d", v), 64'(got_lat), 64'(lat));
    check($sformatf("busy_cycles_%0d", v), 64'(got_busy), 64'(lat - 1));
    check($sformatf("root_%0d", v), 64'(got_root), 64'(er));
    check($sformatf("rem_%0d", v), 64'(got_rem), 64'(erem));
  endtask

  int dcount, dcyc0, dcyc1, gap_idle;
  logic [31:0] r0, m0, r1, m1, rv;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy_a), 64'd0);
    check("reset_done", 64'(done_a), 64'd0);
    check("reset_root", 64'(root_a), 64'd0);
    check("reset_rem",  64'(rem_a),  64'd0);

    expect_op(0, 144, 12, 0, 9);
    expect_op(0, 99, 9, 18, 9);
    expect_op(0, 0, 0, 0, 9);
    expect_op(0, 65535, 255, 510, 9);
    repeat (4) @(negedge clk);
    check("hold_root_idle", 64'(root_a), 64'd255);
    check("hold_rem_idle",  64'(rem_a),  64'd510);
    expect_op(0, 1, 1, 0, 9);
    expect_op(0, 2, 1, 1, 9);

    // start pulses during RUN must be ignored
    sel = 0; dcount = 0; dcyc0 = -1;
    @(negedge clk); drive(0, 1'b1, 10000);
    @(posedge clk); #1 drive(0, 1'b0, 10000);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done_a) begin
        dcount++;
        if (dcyc0 < 0) begin dcyc0 = n; r0 = 32'(root_a); m0 = 32'(rem_a); end
      end
      if (n == 3 || n == 5) drive(0, 1'b1, 4); else drive(0, 1'b0, 4);
    end
    check("busy_start_done_count", 64'(dcount), 64'd1);
    check("busy_start_latency", 64'(dcyc0), 64'd9);
    check("busy_start_root", 64'(r0), 64'd100);
    check("busy_start_rem", 64'(m0), 64'd0);

    // back-to-back with start held high
    dcount = 0; dcyc0 = -1; dcyc1 = -1; gap_idle = 0;
    @(negedge clk); drive(0, 1'b1, 81);
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done_a) begin
        dcount++;
        if (dcount == 1) begin dcyc0 = n; r0 = 32'(root_a); m0 = 32'(rem_a); drive(0, 1'b1, 50); end
        else begin dcyc1 = n; r1 = 32'(root_a); m1 = 32'(rem_a); drive(0, 1'b0, 50); break; end
      end else if (!busy_a) gap_idle++;
    end
    check("b2b_spacing", 64'(dcyc1 - dcyc0), 64'd9);
    check("b2b_root0", 64'(r0), 64'd9);
    check("b2b_rem0", 64'(m0), 64'd0);
    check("b2b_root1", 64'(r1), 64'd7);
    check("b2b_rem1", 64'(m1), 64'd1);
    check("b2b_idle_cycles", 64'(gap_idle), 64'd0);
    repeat (2) @(negedge clk);

    // reset in the middle of RUN
    @(negedge clk); drive(0, 1'b1, 1000);
    @(posedge clk); #1 drive(0, 1'b0, 1000);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy_a), 64'd0);
    check("midrst_done", 64'(done_a), 64'd0);
    check("midrst_root", 64'(root_a), 64'd0);
    check("midrst_rem",  64'(rem_a),  64'd0);
    dcount = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done_a) dcount++;
    end
    check("midrst_no_done", 64'(dcount), 64'd0);
    expect_op(0, 49, 7, 0, 9);

    expect_op(1, 65535, 255, 510, 5);
    expect_op(1, 144, 12, 0, 5);

    expect_op(2, 32'hFFFF_FFFF, 65535, 131070, 9);
    for (int i = 0; i < 12; i++) begin
      rv = $urandom;
      run_op(2, rv);
      check("rand_latency", 64'(got_lat), 64'd9);
      check("rand_square_sum", 64'(got_root) * 64'(got_root) + 64'(got_rem), 64'(rv));
      check("rand_rem_bound", 64'(got_rem <= 2 * got_root), 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
